// File: rtl/team_05_wb_pkg.sv
// team_05 Wishbone master shared types.
// FSM states, access sizes and the default ack timeout.
package team_05_wb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } wbm_state_t;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } wb_size_t;

  localparam int unsigned WB_TIMEOUT_DEFAULT = 255;

  function automatic logic [31:0] size_mask(
    input logic [1:0] sz
  );
    logic [31:0] m;
    m = '0;
    unique case (1'b1)
      sz == SZ_BYTE: m = 32'h0000_00FF;
      sz == SZ_HALF: m = 32'h0000_FFFF;
      sz == SZ_WORD: m = 32'hFFFF_FFFF;
      default:       m = '0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/team_05_wb_lane.sv
// team_05 Wishbone byte-lane steering.
// Selects, write replication, read extraction, misalign flag.
module team_05_wb_lane
  import team_05_wb_pkg::*;
(
  input  logic [1:0]  size_i,
  input  logic [1:0]  addr_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  sel_o,
  output logic [31:0] wdat_o,
  output logic [31:0] rdat_o,
  output logic        misalign_o
);

  always_comb begin
    sel_o      = '0;
    wdat_o     = '0;
    misalign_o = 1'b1;
    unique case (1'b1)
      size_i == SZ_BYTE: begin
        sel_o      = 4'b0001 << addr_i;
        wdat_o     = {4{wdata_i[7:0]}};
        misalign_o = 1'b0;
      end
      size_i == SZ_HALF: begin
        sel_o      = 4'b0011 << addr_i;
        wdat_o     = {2{wdata_i[15:0]}};
        misalign_o = addr_i[0];
      end
      size_i == SZ_WORD: begin
        sel_o      = 4'b1111;
        wdat_o     = wdata_i;
        misalign_o = |addr_i;
      end
      default: begin
        misalign_o = 1'b1;
      end
    endcase
  end

  assign rdat_o = (rdata_i >> {addr_i, 3'b000})
                & size_mask(size_i);

endmodule

// File: rtl/team_05_wb_master.sv
// team_05 Wishbone B4 classic single-transfer initiator.
// Optional ack timeout: TEAM_05_WB_MASTER_TIMEOUT_EN.
module team_05_wb_master
  import team_05_wb_pkg::*;
#(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned TIMEOUT_CYC = WB_TIMEOUT_DEFAULT
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic              busy,
  output logic [ADDR_W-1:0] adr_o,
  output logic [31:0]       dat_o,
  output logic [3:0]        sel_o,
  output logic              we_o,
  output logic              cyc_o,
  output logic              stb_o,
  input  logic [31:0]       dat_i,
  input  logic              ack_i,
  input  logic              err_i
);

  if (TIMEOUT_CYC < 1 || TIMEOUT_CYC > 65535) begin : g_tmo_chk
    $error("TIMEOUT_CYC must be 1..65535");
  end

  wbm_state_t        state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [1:0]        size_q;
  logic              we_q;
  logic [31:0]       wdata_q;
  logic [31:0]       rdata_q, rdata_d;
  logic              err_q, err_d;
  logic              ld;

  logic              idle, in_bus, in_resp;
  logic [1:0]        ln_size, ln_addr;
  logic [3:0]        ln_sel;
  logic [31:0]       ln_wdat, ln_rdat;
  logic              ln_mis;

  assign idle    = (state_q == IDLE);
  assign in_bus  = (state_q == BUS);
  assign in_resp = (state_q == RESP);

  // In IDLE the lane judges the incoming request; afterwards the latched one.
  assign ln_size = idle ? req_size : size_q;
  assign ln_addr = idle ? req_addr[1:0] : addr_q[1:0];

  team_05_wb_lane u_lane (
    .size_i     (ln_size),
    .addr_i     (ln_addr),
    .wdata_i    (wdata_q),
    .rdata_i    (dat_i),
    .sel_o      (ln_sel),
    .wdat_o     (ln_wdat),
    .rdat_o     (ln_rdat),
    .misalign_o (ln_mis)
  );

`ifdef TEAM_05_WB_MASTER_TIMEOUT_EN
  localparam logic [15:0] TMO = 16'(TIMEOUT_CYC);
  logic [15:0] tmo_q, tmo_d;
  logic        tmo_hit;

  assign tmo_d   = in_bus ? tmo_q + 16'd1 : 16'd0;
  assign tmo_hit = in_bus && (tmo_q == TMO);

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) tmo_q <= '0;
    else       tmo_q <= tmo_d;
  end
`else
  logic tmo_hit;
  assign tmo_hit = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    ld      = 1'b0;
    unique case (1'b1)
      state_q == IDLE: begin
        if (req_valid) begin
          ld      = 1'b1;
          rdata_d = '0;
          err_d   = ln_mis;
          state_d = ln_mis ? RESP : BUS;
        end
      end
      state_q == BUS: begin
        if (err_i) begin
          state_d = RESP;
          err_d   = 1'b1;
          rdata_d = '0;
        end else if (ack_i) begin
          state_d = RESP;
          err_d   = 1'b0;
          rdata_d = we_q ? '0 : ln_rdat;
        end else if (tmo_hit) begin
          state_d = RESP;
          err_d   = 1'b1;
          rdata_d = '0;
        end
      end
      state_q == RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= IDLE;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      addr_q  <= '0;
      size_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
    end else if (ld) begin
      addr_q  <= req_addr;
      size_q  <= req_size;
      we_q    <= req_write;
      wdata_q <= req_wdata;
    end
  end

  assign req_ready = idle;
  assign busy      = !idle;
  assign cyc_o     = in_bus;
  assign stb_o     = in_bus;
  assign we_o      = in_bus & we_q;
  assign adr_o     = in_bus ? {addr_q[ADDR_W-1:2], 2'b00} : '0;
  assign sel_o     = in_bus ? ln_sel : '0;
  assign dat_o     = in_bus ? ln_wdat : '0;
  assign rsp_valid = in_resp;
  assign rsp_err   = in_resp & err_q;
  assign rsp_rdata = in_resp ? rdata_q : '0;

endmodule
